// File: rtl/run_key_ctrl.sv
// rtl/run_key_ctrl.sv - debounced run/pause and long-press restart front end
// for the traffic-light timer; one clock cycle equals one millisecond.
module run_key_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 2000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_n,
  output logic en,
  output logic restart
);

  localparam int DEB_W  = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int HOLD_W = (LONG_MS > 1) ? $clog2(LONG_MS) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              key_db_q, key_db_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic              restart_q, restart_d;

  // Two-flop synchroniser; idle (released) level is 1.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // A new level is only accepted after DEBOUNCE_MS consecutive differing samples.
  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == key_db_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      key_db_d  = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // Press classifier; restart defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    en_d       = en_q;
    restart_d  = 1'b0;
    case (state_q)
      REL: begin
        if (!key_db_q) begin
          state_d    = PRESS;
          hold_cnt_d = '0;
        end
      end
      PRESS: begin
        if (key_db_q) begin
          state_d = REL;
          en_d    = ~en_q;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = LONG;
          restart_d = 1'b1;
          en_d      = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      LONG: begin
        // hold_cnt is frozen here so it can never wrap on a very long hold.
        if (key_db_q) begin
          state_d = REL;
        end
      end
      default: begin
        state_d = REL;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      key_db_q   <= 1'b1;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      state_q    <= REL;
      en_q       <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      key_db_q   <= key_db_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      en_q       <= en_d;
      restart_q  <= restart_d;
    end
  end

  assign en      = en_q;
  assign restart = restart_q;

endmodule

// File: tb/tb_run_key_ctrl.sv
// tb/tb_run_key_ctrl.sv - directed self-checking bench for run_key_ctrl
// with default DEBOUNCE_MS=20, LONG_MS=2000.
module tb_run_key_ctrl;

  logic Clk;
  logic Rst;
  logic key_n;
  logic en;
  logic restart;

  int n_checks;
  int n_errors;
  int n_pulses;
  int pulses_base;

  run_key_ctrl dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .key_n   (key_n),
    .en      (en),
    .restart (restart)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (restart) n_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Release edge 1 is the first edge after key_n goes high; en moves at edge 23.
  task automatic release_and_check(input string tag, input logic en_before, input logic en_after);
    key_n = 1'b1;
    tick(22);
    check({tag, "_edge22"}, 32'(en), 32'(en_before));
    tick(1);
    check({tag, "_edge23"}, 32'(en), 32'(en_after));
  endtask

  task automatic bounce(input int cycles, input logic first);
    logic lvl;
    lvl = first;
    for (int i = 0; i < cycles; i += 5) begin
      key_n = lvl;
      tick(5);
      lvl = ~lvl;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pulses = 0;
    Rst      = 1'b1;
    key_n    = 1'b1;

    // 1: reset
    tick(3);
    check("reset_en", 32'(en), 32'd0);
    check("reset_restart", 32'(restart), 32'd0);
    Rst = 1'b0;
    tick(5);
    check("idle_en", 32'(en), 32'd0);

    // 2: two 100-cycle presses
    pulses_base = n_pulses;
    key_n = 1'b0;
    tick(100);
    check("press1_held_en", 32'(en), 32'd0);
    release_and_check("press1", 1'b0, 1'b1);
    tick(20);
    key_n = 1'b0;
    tick(100);
    release_and_check("press2", 1'b1, 1'b0);
    tick(20);
    check("press12_no_restart", 32'(n_pulses - pulses_base), 32'd0);

    // 3: bouncy press
    pulses_base = n_pulses;
    bounce(60, 1'b0);
    key_n = 1'b0;
    tick(80);
    check("bounce_held_en", 32'(en), 32'd0);
    bounce(60, 1'b1);
    key_n = 1'b1;
    tick(40);
    check("bounce_one_toggle", 32'(en), 32'd1);
    check("bounce_no_restart", 32'(n_pulses - pulses_base), 32'd0);

    // 4: 19-cycle glitch ignored, 20-cycle pulse is a short press
    key_n = 1'b0;
    tick(19);
    key_n = 1'b1;
    tick(60);
    check("glitch19_en", 32'(en), 32'd1);
    key_n = 1'b0;
    tick(20);
    release_and_check("pulse20", 1'b1, 1'b0);
    tick(20);

    // 5: long press from RUN
    key_n = 1'b0;
    tick(40);
    release_and_check("pre_long", 1'b0, 1'b1);
    tick(20);
    pulses_base = n_pulses;
    key_n = 1'b0;
    tick(2022);
    check("long_pre_restart", 32'(restart), 32'd0);
    check("long_pre_en", 32'(en), 32'd1);
    tick(1);
    check("long_restart_edge", 32'(restart), 32'd1);
    check("long_en_cleared", 32'(en), 32'd0);
    tick(1);
    check("long_restart_one_cycle", 32'(restart), 32'd0);
    tick(2500 - 2024);
    key_n = 1'b1;
    tick(40);
    check("long_release_en", 32'(en), 32'd0);
    check("long_single_pulse", 32'(n_pulses - pulses_base), 32'd1);

    // 6: reset mid-press, key held through reset
    key_n = 1'b0;
    tick(40);
    release_and_check("pre_rst", 1'b0, 1'b1);
    tick(20);
    pulses_base = n_pulses;
    key_n = 1'b0;
    tick(100);
    Rst = 1'b1;
    tick(3);
    check("midrst_en", 32'(en), 32'd0);
    check("midrst_restart", 32'(restart), 32'd0);
    Rst = 1'b0;
    tick(100);
    check("midrst_held_en", 32'(en), 32'd0);
    release_and_check("midrst_release", 1'b0, 1'b1);
    tick(20);
    check("midrst_no_restart", 32'(n_pulses - pulses_base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
